// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Holds the access-size and FSM state encodings plus the byte-enable mask helper.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } accSizeE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateE;

    // Byte-enable mask for a size at a lane offset; callers truncate to their lane count.
    function automatic logic [7:0] beMask(input accSizeE size, input logic [2:0] offset);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << offset;
    endfunction

    // Offset bits that must be zero for an aligned access of this size.
    function automatic logic [2:0] alignMask(input accSizeE size);
        case (size)
            SZ_B:    return 3'd0;
            SZ_H:    return 3'd1;
            SZ_W:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: moves the addressed lane down to bit 0 and sign/zero-extends it.
module load_extend
    import mem_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [OFF_W-1:0] offset,
    input  accSizeE          size,
    input  logic             isUnsigned,
    output logic [XLEN-1:0]  data
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            signBit;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        mask    = '1;
        signBit = shifted[XLEN-1];
        case (size)
            SZ_B: begin
                mask    = XLEN'(8'hFF);
                signBit = shifted[7];
            end
            SZ_H: begin
                mask    = XLEN'(16'hFFFF);
                signBit = shifted[15];
            end
            SZ_W: begin
                mask    = XLEN'(32'hFFFF_FFFF);
                signBit = shifted[31];
            end
            default: ;
        endcase
        // A full-width mask leaves nothing above the sign bit, so full-width loads pass through.
        if (isUnsigned || !signBit) begin
            data = shifted & mask;
        end else begin
            data = shifted | ~mask;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Handshaked memory-stage load/store unit: IDLE -> BUSY -> DONE with registered outputs.
// Define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES cycles and flag bus_error.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_store,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                stallM,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                misaligned,
    output logic                bus_error,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_ready,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);

    stateE             stateReg, stateNext;
    logic              accept, reject, done, timeout;
    accSizeE           reqSize;
    logic [OFF_W-1:0]  reqOff;
    logic              legal;
    logic [XLEN-1:0]   wdataRep;
    logic [XLEN-1:0]   loadData;

    logic              memReqReg, memWeReg, respValidReg, misalignedReg;
    logic [ADDR_W-1:0] memAddrReg;
    logic [BE_W-1:0]   memBeReg;
    logic [XLEN-1:0]   memWdataReg, respRdataReg;
    logic [OFF_W-1:0]  offReg;
    accSizeE           sizeReg;
    logic              unsignedReg;

    assign reqSize = accSizeE'(req_size);
    assign reqOff  = req_addr[OFF_W-1:0];
    assign legal   = ((reqSize != SZ_D) || (XLEN == 64))
                   && ((3'(reqOff) & alignMask(reqSize)) == 3'd0);

    always_comb begin
        case (reqSize)
            SZ_B:    wdataRep = {BE_W{req_wdata[7:0]}};
            SZ_H:    wdataRep = {(BE_W / 2){req_wdata[15:0]}};
            SZ_W:    wdataRep = {(BE_W / 4){req_wdata[31:0]}};
            default: wdataRep = req_wdata;
        endcase
    end

    load_extend #(.XLEN(XLEN), .OFF_W(OFF_W)) u_load_extend (
        .rdata      (mem_rdata),
        .offset     (offReg),
        .size       (sizeReg),
        .isUnsigned (unsignedReg),
        .data       (loadData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        accept    = 1'b0;
        reject    = 1'b0;
        done      = 1'b0;
        case (stateReg)
            IDLE: begin
                if (req_valid) begin
                    if (legal) begin
                        accept    = 1'b1;
                        stateNext = BUSY;
                    end else begin
                        reject    = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mem_ready || timeout) begin
                    done      = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // The accept cycle must stall before the state register has moved to BUSY.
    assign stallM = accept || (stateReg == BUSY);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cntReg;
    logic             busErrorReg;

    assign timeout   = (stateReg == BUSY) && !mem_ready
                     && (cntReg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_error = busErrorReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cntReg      <= '0;
            busErrorReg <= 1'b0;
        end else begin
            busErrorReg <= timeout;
            if (accept) begin
                cntReg <= '0;
            end else if (stateReg == BUSY) begin
                cntReg <= cntReg + 1'b1;
            end
        end
    end
`else
    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            memReqReg     <= 1'b0;
            memWeReg      <= 1'b0;
            memAddrReg    <= '0;
            memBeReg      <= '0;
            memWdataReg   <= '0;
            respValidReg  <= 1'b0;
            respRdataReg  <= '0;
            misalignedReg <= 1'b0;
            offReg        <= '0;
            sizeReg       <= SZ_B;
            unsignedReg   <= 1'b0;
        end else begin
            misalignedReg <= reject;
            respValidReg  <= done;
            if (accept) begin
                memReqReg   <= 1'b1;
                memWeReg    <= req_store;
                memAddrReg  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                memBeReg    <= BE_W'(beMask(reqSize, 3'(reqOff)));
                memWdataReg <= wdataRep;
                offReg      <= reqOff;
                sizeReg     <= reqSize;
                unsignedReg <= req_unsigned;
            end
            if (done) begin
                memReqReg    <= 1'b0;
                respRdataReg <= (memWeReg || timeout) ? '0 : loadData;
            end
        end
    end

    assign mem_req    = memReqReg;
    assign mem_we     = memWeReg;
    assign mem_addr   = memAddrReg;
    assign mem_be     = memBeReg;
    assign mem_wdata  = memWdataReg;
    assign resp_valid = respValidReg;
    assign resp_rdata = respRdataReg;
    assign misaligned = misalignedReg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit at XLEN=32; timeout sequence runs when MEM_TIMEOUT_EN is set.
module tb_mem_access_unit;

    typedef struct {
        logic        store;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        expMis;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expRdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stallM, resp_valid, misaligned, bus_error;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int   total  = 0;
    int   passed = 0;
    int   waitCnt;
    vec_t vecs[13];
    vec_t rstVec;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_store    (req_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stallM       (stallM),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .misaligned   (misaligned),
        .bus_error    (bus_error),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic runVec(input vec_t v, input int idx);
        int stalls;
        @(negedge clk);
        req_valid    = 1'b1;
        req_store    = v.store;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        mem_ready    = 1'b0;
        mem_rdata    = 32'hDEAD_BEEF;
        #1;
        stalls = stallM ? 1 : 0;
        if (v.expMis) chk($sformatf("v%0d rejectStall", idx), {31'd0, stallM}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.expMis) begin
            chk($sformatf("v%0d misaligned", idx), {31'd0, misaligned}, 32'd1);
            chk($sformatf("v%0d noMemReq", idx), {31'd0, mem_req}, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d misPulse", idx), {31'd0, misaligned}, 32'd0);
            chk($sformatf("v%0d noMemReq2", idx), {31'd0, mem_req}, 32'd0);
            $display("vec %0d addr=%h size=%0d -> misaligned", idx, v.addr, v.size);
        end else begin
            chk($sformatf("v%0d memReq", idx), {31'd0, mem_req}, 32'd1);
            chk($sformatf("v%0d memWe", idx), {31'd0, mem_we}, {31'd0, v.store});
            chk($sformatf("v%0d memAddr", idx), mem_addr, v.expAddr);
            chk($sformatf("v%0d memBe", idx), {28'd0, mem_be}, {28'd0, v.expBe});
            if (v.store) chk($sformatf("v%0d memWdata", idx), mem_wdata, v.expWdata);
            for (int i = 0; i <= v.delay; i++) begin
                mem_ready = (i == v.delay);
                mem_rdata = mem_ready ? v.rdata : 32'hDEAD_BEEF;
                #1;
                if (stallM) stalls++;
                @(negedge clk);
            end
            mem_ready = 1'b0;
            mem_rdata = 32'h0;
            chk($sformatf("v%0d respValid", idx), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("v%0d respRdata", idx), resp_rdata, v.expRdata);
            chk($sformatf("v%0d stallDone", idx), {31'd0, stallM}, 32'd0);
            chk($sformatf("v%0d memReqDone", idx), {31'd0, mem_req}, 32'd0);
            chk($sformatf("v%0d busError", idx), {31'd0, bus_error}, 32'd0);
            chk($sformatf("v%0d stallCycles", idx), stalls, v.delay + 2);
            @(negedge clk);
            chk($sformatf("v%0d respPulse", idx), {31'd0, resp_valid}, 32'd0);
            $display("vec %0d addr=%h size=%0d store=%0d be=%b rdata=%h stalls=%0d",
                     idx, v.addr, v.size, v.store, mem_be, resp_rdata, stalls);
        end
    endtask

    initial begin
        //           st    sz    uns   addr      wdata         rdata         dly mis   expAddr   expBe    expWdata      expRdata
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'h80FF1234, 1, 1'b0, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80};
        vecs[1]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'h80010000, 0, 1'b0, 32'h100, 4'b1100, 32'h0,        32'h00008001};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h101, 32'h000000AB, 32'h12345678, 0, 1'b0, 32'h100, 4'b0010, 32'hABABABAB, 32'h0};
        vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h106, 32'h0,        32'hF00DBEEF, 2, 1'b0, 32'h104, 4'b1100, 32'h0,        32'hFFFFF00D};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h208, 32'h0,        32'h89ABCDEF, 0, 1'b0, 32'h208, 4'b1111, 32'h0,        32'h89ABCDEF};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h302, 32'h1234BEEF, 32'h0,        1, 1'b0, 32'h300, 4'b1100, 32'hBEEFBEEF, 32'h0};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h404, 32'hCAFEF00D, 32'h0,        0, 1'b0, 32'h404, 4'b1111, 32'hCAFEF00D, 32'h0};
        vecs[9]  = '{1'b0, 2'd0, 1'b1, 32'h100, 32'h0,        32'h000000F0, 0, 1'b0, 32'h100, 4'b0001, 32'h0,        32'h000000F0};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h101, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 32'h102, 32'h0,        32'h00450000, 0, 1'b0, 32'h100, 4'b0100, 32'h0,        32'h00000045};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h101, 32'h0,        32'h0000A500, 3, 1'b0, 32'h100, 4'b0010, 32'h0,        32'hFFFFFFA5};
        rstVec   = '{1'b0, 2'd2, 1'b0, 32'h200, 32'h0,        32'h11223344, 1, 1'b0, 32'h200, 4'b1111, 32'h0,        32'h11223344};

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_store    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mem_ready    = 1'b0;
        mem_rdata    = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst memReq", {31'd0, mem_req}, 32'd0);
        chk("rst respValid", {31'd0, resp_valid}, 32'd0);
        chk("rst stallM", {31'd0, stallM}, 32'd0);
        chk("rst misaligned", {31'd0, misaligned}, 32'd0);
        chk("rst memBe", {28'd0, mem_be}, 32'd0);
        chk("rst respRdata", resp_rdata, 32'd0);
        $display("reset state checked");

        for (int i = 0; i < 13; i++) begin
            runVec(vecs[i], i);
        end

        // Reset while the memory is still busy must abandon the access silently.
        @(negedge clk);
        req_valid = 1'b1;
        req_store = 1'b0;
        req_size  = 2'd2;
        req_unsigned = 1'b0;
        req_addr  = 32'h200;
        mem_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("midRst memReqBusy", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midRst memReq", {31'd0, mem_req}, 32'd0);
        chk("midRst stallM", {31'd0, stallM}, 32'd0);
        chk("midRst respValid", {31'd0, resp_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midRst noResp", {31'd0, resp_valid}, 32'd0);
        $display("reset during BUSY: mem_req=%0d resp_valid=%0d", mem_req, resp_valid);
        runVec(rstVec, 100);

`ifdef MEM_TIMEOUT_EN
        @(negedge clk);
        req_valid = 1'b1;
        req_store = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h300;
        mem_ready = 1'b0;
        mem_rdata = 32'h5555_5555;
        @(negedge clk);
        req_valid = 1'b0;
        waitCnt = 0;
        while (!resp_valid && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        chk("tmo busyCycles", waitCnt, 32'd4);
        chk("tmo respValid", {31'd0, resp_valid}, 32'd1);
        chk("tmo busError", {31'd0, bus_error}, 32'd1);
        chk("tmo respRdata", resp_rdata, 32'd0);
        chk("tmo stallM", {31'd0, stallM}, 32'd0);
        chk("tmo memReq", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk("tmo busErrPulse", {31'd0, bus_error}, 32'd0);
        $display("timeout after %0d BUSY cycles bus_error pulse seen", waitCnt);
`else
        waitCnt = 0;
        chk("noTmo busError", {31'd0, bus_error}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage load/store unit for the pipelined MIPS core. It replaces fixed single-cycle word access plus writeback-stage byte selection with a parametrised, handshaked access path. It supports byte, half, word and (XLEN=64) dword accesses, signed or unsigned. It stalls the pipeline until variable-latency memory responds and returns aligned, extended load data.

Parameters:
XLEN, 32, data/register width; 32 or 64
ADDR_W, 32, byte-address width
TIMEOUT_CYCLES, 255, BUSY-cycle limit before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  M-stage instruction is a load/store
req_store  in  1  1 = store, 0 = load
req_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword illegal when XLEN=32)
req_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
req_addr  in  ADDR_W  byte address (aluoutM)
req_wdata  in  XLEN  store data (writedataM), right-justified
stallM  out  1  hold F/D/E/M stages
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  XLEN  extended load data (0 for stores)
misaligned  out  1  one-cycle pulse: address not size-aligned, or illegal size
bus_error  out  1  one-cycle pulse on timeout (0 without macro)
mem_req  out  1  memory request, held until accepted
mem_we  out  1  write enable
mem_addr  out  ADDR_W  lane-aligned address (low log2(XLEN/8) bits zero)
mem_be  out  XLEN/8  byte enables
mem_wdata  out  XLEN  lane-replicated store data
mem_ready  in  1  memory accepts/completes request this cycle
mem_rdata  in  XLEN  read data, valid when mem_ready=1

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-transaction abandons it; mem_req drops at that edge. No response is produced.
- FSM IDLE -> BUSY -> DONE -> IDLE, all outputs registered.
- IDLE, req_valid and aligned/legal: latch request, mem_req=1, go to BUSY. stallM=1 combinationally this cycle.
- IDLE, req_valid and misaligned/illegal: no memory access, misaligned=1 next cycle, stallM=0, stay IDLE.
- BUSY: mem_req/mem_we/mem_addr/mem_be/mem_wdata stay stable; stallM=1. When mem_ready=1, capture extended mem_rdata (loads) and go to DONE.
- DONE: mem_req=0, resp_valid=1, stallM=0, so the pipeline advances. Go to IDLE. A new request is seen in the following IDLE cycle.
- mem_ready is ignored outside BUSY.
- Minimum latency is 2 stalled cycles: accept cycle, plus a BUSY cycle with mem_ready=1.
- Little-endian. Lane offset is addr[log2(XLEN/8)-1:0]. mem_be is the size mask (1/3/F/FF) shifted left by the offset.
- mem_wdata: byte replicated to all lanes, half replicated, word replicated (XLEN=64).
- Load: shift mem_rdata right by offset*8, take the size bits, then sign- or zero-extend per req_unsigned. Word loads at XLEN=32 are unaffected by req_unsigned.
- Alignment rule: offset mod size_bytes == 0.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: an 8+ bit counter runs in BUSY. After TIMEOUT_CYCLES BUSY cycles without mem_ready, drop mem_req, go to DONE with resp_rdata=0, and pulse bus_error alongside resp_valid.
- Undefined: no counter, BUSY waits indefinitely, bus_error tied 0.

Decomposition:
- Package mem_pkg holds:
  - access-size enum (SZ_B, SZ_H, SZ_W, SZ_D)
  - FSM state enum (IDLE, BUSY, DONE)
  - function returning the byte-enable mask for size and offset
- One combinational sub-module, load_extend: lane shift plus sign/zero extension, parametrised on XLEN.

Test Plan:
1. XLEN=32. lb at 0x103, mem_ready on the 2nd BUSY cycle with mem_rdata 0x80FF1234 -> mem_be=4'b1000, stallM high 3 cycles, resp_rdata=0xFFFFFF80.
2. lhu at 0x102, mem_ready on the 1st BUSY cycle with mem_rdata 0x80010000 -> mem_be=4'b1100, mem_addr=0x100, resp_rdata=0x00008001, stallM high 2 cycles.
3. sb at 0x101 with req_wdata 0x000000AB -> mem_we=1, mem_be=4'b0010, mem_wdata=0xABABABAB, resp_valid pulse, resp_rdata=0.
4. lw at 0x102 -> misaligned pulse, mem_req never asserted, stallM=0; dword with XLEN=32 also raises misaligned.
5. reset asserted during BUSY -> next cycle mem_req=0, stallM=0, no resp_valid; a following lw at 0x200 completes normally.
6. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready held 0 -> after 4 BUSY cycles bus_error and resp_valid pulse together, resp_rdata=0, stallM released.
